fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues requests to a variable-latency instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small in-order queue that presents {inst, pc4} with a valid flag to IF/ID. It honours hazard stalls and branch/jump redirects, and discards stale in-flight responses after a redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Consumers import fetch_pkg::* for the entry layout and the count-width helper.
package fetch_pkg;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

    // Bits needed to hold an occupancy count from 0 up to depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with push/pop/clear and count/empty status.
// Used both as the instruction queue and as the in-flight tag FIFO.
module fetch_fifo import fetch_pkg::*; #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests; a push into a full FIFO is accepted only alongside a pop
    always_comb begin
        do_pop_s  = pop & (count_r != {CW{1'b0}});
        do_push_s = push & ((count_r != CW'(DEPTH)) | do_pop_s);
        empty     = (count_r == {CW{1'b0}});
        count     = count_r;
        rdata     = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed through count-qualified reads
    always_ff @(posedge clk) begin
        if (do_push_s && !clear && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt requests and queues
// in-order responses for IF/ID. Optional macro FETCH_BYPASS_EN adds a response bypass.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic [31:0] pc_o
);

    localparam int unsigned CW       = cnt_width(QDEPTH);
    localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_r;
    logic [CW-1:0] discard_r;

    logic [CW:0]   inflight_total_s;
    logic          fire_s;
    logic          resp_s;
    logic          keep_s;
    logic          q_push_s;
    logic          q_pop_s;
    logic          q_empty_s;
    logic [CW-1:0] q_count_s;
    fetch_entry_t  q_wdata_s;
    fetch_entry_t  q_head_s;
    logic          tag_empty_s;
    logic [CW-1:0] tag_count_s;
    logic [31:0]   tag_head_s;
`ifdef FETCH_BYPASS_EN
    logic          bypass_s;
`endif

    // Credit check uses registered counts only, so a pop never frees a slot this cycle
    always_comb begin
        inflight_total_s = {1'b0, tag_count_s} + {1'b0, q_count_s};
        imem_req_o       = start_i & ~redirect_i & ~rst_i & (inflight_total_s < QDEPTH_W);
        imem_addr_o      = pc_r;
        pc_o             = pc_r;
        fire_s           = imem_req_o & imem_gnt_i;
        resp_s           = imem_rvalid_i & ~tag_empty_s;
        keep_s           = resp_s & ~redirect_i & (discard_r == {CW{1'b0}});
        q_pop_s          = ~q_empty_s & ~stall_i & ~redirect_i;
        q_wdata_s        = '{inst: imem_rdata_i, pc4: tag_head_s};
`ifdef FETCH_BYPASS_EN
        bypass_s         = keep_s & q_empty_s;
        q_push_s         = keep_s & ~(bypass_s & ~stall_i);
`else
        q_push_s         = keep_s;
`endif
    end

    // IF/ID view of the queue head (or of the bypassed response when enabled)
    always_comb begin
        if (!q_empty_s) begin
            inst_valid_o = 1'b1;
            inst_o       = q_head_s.inst;
            pc4_o        = q_head_s.pc4;
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass_s) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            pc4_o        = tag_head_s;
        end
`endif
        else begin
            inst_valid_o = 1'b0;
            inst_o       = 32'h0000_0000;
            pc4_o        = 32'h0000_0000;
        end
    end

    // Fetch PC: reset, then redirect, then advance on an accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r <= RESET_PC;
        end else if (redirect_i) begin
            pc_r <= redirect_pc_i;
        end else if (fire_s) begin
            pc_r <= pc_r + PC_INC;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Stale-response counter: everything still outstanding after a redirect is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_r <= {CW{1'b0}};
        end else if (redirect_i) begin
            discard_r <= resp_s ? (tag_count_s - CW'(1'b1)) : tag_count_s;
        end else if (resp_s && (discard_r != {CW{1'b0}})) begin
            discard_r <= discard_r - CW'(1'b1);
        end else begin
            discard_r <= discard_r;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (1'b0),
        .push  (fire_s),
        .wdata (pc_r + PC_INC),
        .pop   (resp_s),
        .rdata (tag_head_s),
        .empty (tag_empty_s),
        .count (tag_count_s)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_inst_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (redirect_i),
        .push  (q_push_s),
        .wdata (q_wdata_s),
        .pop   (q_pop_s),
        .rdata (q_head_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory timing against a queue-based
// reference model, plus directed scenarios for stall, redirect, gnt hold and reset.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
`ifdef FETCH_BYPASS_EN
    localparam int          FIRST_VALID = 1;
`else
    localparam int          FIRST_VALID = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc4_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc4_o(pc4_o), .pc_o(pc_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc = RESET_PC;
    int          m_disc = 0;
    logic [31:0] m_tags[$];
    logic [63:0] m_q[$];
    // memory model: granted addresses awaiting a response
    logic [31:0] mem_q[$];
    bit          rd_override = 1'b0;
    logic [31:0] rd_value = 32'h0;
    // expected outputs for the current cycle
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_inst, e_pc4;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic model_eval();
        int total;
        total   = m_tags.size() + m_q.size();
        e_req   = start_i && !redirect_i && !rst_i && (total < QDEPTH);
        e_addr  = m_pc;
        e_valid = (m_q.size() > 0);
        e_inst  = e_valid ? m_q[0][63:32] : 32'h0;
        e_pc4   = e_valid ? m_q[0][31:0]  : 32'h0;
`ifdef FETCH_BYPASS_EN
        if (!e_valid && imem_rvalid_i && m_disc == 0 && !redirect_i && !rst_i && m_tags.size() > 0) begin
            e_valid = 1'b1;
            e_inst  = imem_rdata_i;
            e_pc4   = m_tags[0];
        end
`endif
    endtask

    task automatic drive(input logic st, input logic sl, input logic rd, input logic [31:0] rpc,
                         input int gp, input int rp);
        start_i       = st;
        stall_i       = sl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_gnt_i    = ($urandom_range(0, 99) < gp);
        imem_rvalid_i = (mem_q.size() > 0) && ($urandom_range(0, 99) < rp);
        imem_rdata_i  = imem_rvalid_i ? (rd_override ? rd_value : inst_of(mem_q[0])) : 32'hDEAD_BEEF;
        #1;
        model_eval();
    endtask

    task automatic step();
        logic        dut_fire;
        logic [31:0] dut_addr;
        logic        rv;
        logic [31:0] tag;
        bit          got;
        bit          byp;
        dut_fire = imem_req_o && imem_gnt_i;
        dut_addr = imem_addr_o;
        rv       = imem_rvalid_i;
        got      = 1'b0;
        byp      = 1'b0;
        tag      = 32'h0;
        @(posedge clk);
        if (rst_i) begin
            mem_q.delete();
            m_pc = RESET_PC; m_disc = 0; m_tags.delete(); m_q.delete();
        end else begin
            if (rv) void'(mem_q.pop_front());
            if (dut_fire) mem_q.push_back(dut_addr);
            if (rv && m_tags.size() > 0) begin tag = m_tags.pop_front(); got = 1'b1; end
            if (redirect_i) begin
                m_q.delete();
                m_pc   = redirect_pc_i;
                m_disc = m_tags.size();
            end else begin
`ifdef FETCH_BYPASS_EN
                byp = got && m_disc == 0 && m_q.size() == 0 && !stall_i;
`endif
                if (m_q.size() > 0 && !stall_i) void'(m_q.pop_front());
                if (got) begin
                    if (m_disc > 0) m_disc--;
                    else if (!byp) m_q.push_back({imem_rdata_i, tag});
                end
                if (e_req && imem_gnt_i) begin
                    m_tags.push_back(m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rd_override = 1'b0;
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
            step();
        end
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 100, 100);
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", imem_req_o); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", inst_valid_o); end
        n_cmp++; if (inst_o !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h want=0", inst_o); end
        n_cmp++; if (pc4_o !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got=%h want=0", pc4_o); end
        n_cmp++; if (pc_o !== RESET_PC) begin n_err++; $display("FAIL reset_pc got=%h want=%h", pc_o, RESET_PC); end
        step();
    endtask

    task automatic test_stream();
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            n_cmp++; if (imem_req_o !== e_req) begin n_err++; $display("FAIL stream_req c=%0d got=%b want=%b", c, imem_req_o, e_req); end
            n_cmp++; if (imem_addr_o !== e_addr) begin n_err++; $display("FAIL stream_addr c=%0d got=%h want=%h", c, imem_addr_o, e_addr); end
            n_cmp++; if (inst_valid_o !== e_valid) begin n_err++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, inst_valid_o, e_valid); end
            n_cmp++; if (inst_o !== e_inst) begin n_err++; $display("FAIL stream_inst c=%0d got=%h want=%h", c, inst_o, e_inst); end
            n_cmp++; if (pc4_o !== e_pc4) begin n_err++; $display("FAIL stream_pc4 c=%0d got=%h want=%h", c, pc4_o, e_pc4); end
            if (c < FIRST_VALID) begin
                n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_early c=%0d got=%b want=0", c, inst_valid_o); end
            end
            if (c == FIRST_VALID) begin
                n_cmp++; if (inst_valid_o !== 1'b1 || pc4_o !== 32'h4)
                    begin n_err++; $display("FAIL stream_first c=%0d got=%b/%h want=1/00000004", c, inst_valid_o, pc4_o); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] last_pc4;
        logic [31:0] held;
        bit          held_set;
        apply_reset();
        last_pc4 = RESET_PC;
        held_set = 1'b0;
        held     = 32'h0;
        for (int c = 0; c < 18; c++) begin
            logic sl;
            sl = (c >= 4 && c < 8);
            drive(1'b1, sl, 1'b0, 32'h0, 100, 100);
            n_cmp++; if (imem_req_o !== e_req) begin n_err++; $display("FAIL stall_req c=%0d got=%b want=%b", c, imem_req_o, e_req); end
            n_cmp++; if (inst_o !== e_inst) begin n_err++; $display("FAIL stall_inst c=%0d got=%h want=%h", c, inst_o, e_inst); end
            if (sl && held_set) begin
                n_cmp++; if (inst_o !== held) begin n_err++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, inst_o, held); end
            end
            if (sl && !held_set && inst_valid_o) begin held = inst_o; held_set = 1'b1; end
            if (c == 7) begin
                n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_credit got=%b want=0", imem_req_o); end
            end
            if (inst_valid_o && !sl) begin
                n_cmp++; if (pc4_o !== last_pc4 + 32'd4) begin n_err++; $display("FAIL stall_order c=%0d got=%h want=%h", c, pc4_o, last_pc4 + 32'd4); end
                n_cmp++; if (inst_o !== inst_of(pc4_o - 32'd4)) begin n_err++; $display("FAIL stall_data c=%0d got=%h want=%h", c, inst_o, inst_of(pc4_o - 32'd4)); end
                last_pc4 = pc4_o;
            end
            step();
        end
    endtask

    task automatic test_redirect();
        bit seen;
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 0);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 100, 0);
        n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL redir_noreq got=%b want=0", imem_req_o); end
        step();
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            if (c == 0) begin
                n_cmp++; if (imem_addr_o !== 32'h0000_0100) begin n_err++; $display("FAIL redir_addr got=%h want=00000100", imem_addr_o); end
            end
            n_cmp++; if (imem_req_o !== e_req) begin n_err++; $display("FAIL redir_req c=%0d got=%b want=%b", c, imem_req_o, e_req); end
            n_cmp++; if (pc4_o !== e_pc4) begin n_err++; $display("FAIL redir_pc4 c=%0d got=%h want=%h", c, pc4_o, e_pc4); end
            if (inst_valid_o && !seen) begin
                seen = 1'b1;
                n_cmp++; if (pc4_o !== 32'h0000_0104) begin n_err++; $display("FAIL redir_first got=%h want=00000104", pc4_o); end
            end
            step();
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL redir_timeout got=none want=valid"); end
    endtask

    task automatic test_gnt_hold();
        logic        prev_wait;
        logic [31:0] prev_addr;
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            step();
        end
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 0, 100);
            n_cmp++; if (imem_addr_o !== 32'h8) begin n_err++; $display("FAIL hold_addr c=%0d got=%h want=00000008", c, imem_addr_o); end
            n_cmp++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL hold_pc c=%0d got=%h want=00000008", c, pc_o); end
            n_cmp++; if (imem_req_o !== e_req) begin n_err++; $display("FAIL hold_req c=%0d got=%b want=%b", c, imem_req_o, e_req); end
            if (prev_wait) begin
                n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr)
                    begin n_err++; $display("FAIL hold_stable c=%0d got=%b/%h want=1/%h", c, imem_req_o, imem_addr_o, prev_addr); end
            end
            prev_wait = imem_req_o;
            prev_addr = imem_addr_o;
            step();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            n_cmp++; if (imem_addr_o !== e_addr) begin n_err++; $display("FAIL hold_resume c=%0d got=%h want=%h", c, imem_addr_o, e_addr); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 100, 100);
        n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_queued got=%b want=1", inst_valid_o); end
        step();
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        step();
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b want=0", inst_valid_o); end
        n_cmp++; if (pc_o !== RESET_PC) begin n_err++; $display("FAIL rstmid_pc got=%h want=%h", pc_o, RESET_PC); end
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC)
            begin n_err++; $display("FAIL rstmid_restart got=%b/%h want=1/%h", imem_req_o, imem_addr_o, RESET_PC); end
        step();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
            n_cmp++; if (pc4_o !== e_pc4) begin n_err++; $display("FAIL rstmid_pc4 c=%0d got=%h want=%h", c, pc4_o, e_pc4); end
            step();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
            drive($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5, rpc, 70, 70);
            n_cmp++; if (imem_req_o !== e_req) begin n_err++; $display("FAIL rand_req c=%0d got=%b want=%b", c, imem_req_o, e_req); end
            n_cmp++; if (imem_addr_o !== e_addr) begin n_err++; $display("FAIL rand_addr c=%0d got=%h want=%h", c, imem_addr_o, e_addr); end
            n_cmp++; if (pc_o !== e_addr) begin n_err++; $display("FAIL rand_pc c=%0d got=%h want=%h", c, pc_o, e_addr); end
            n_cmp++; if (inst_valid_o !== e_valid) begin n_err++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, inst_valid_o, e_valid); end
            n_cmp++; if (inst_o !== e_inst) begin n_err++; $display("FAIL rand_inst c=%0d got=%h want=%h", c, inst_o, e_inst); end
            n_cmp++; if (pc4_o !== e_pc4) begin n_err++; $display("FAIL rand_pc4 c=%0d got=%h want=%h", c, pc4_o, e_pc4); end
            step();
        end
    endtask

`ifdef FETCH_BYPASS_EN
    task automatic test_bypass();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 100, 0);
        step();
        rd_override = 1'b1;
        rd_value    = 32'h2002_0005;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL byp_valid got=%b want=1", inst_valid_o); end
        n_cmp++; if (inst_o !== 32'h2002_0005) begin n_err++; $display("FAIL byp_inst got=%h want=20020005", inst_o); end
        n_cmp++; if (pc4_o !== 32'h4) begin n_err++; $display("FAIL byp_pc4 got=%h want=00000004", pc4_o); end
        step();
        rd_override = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL byp_empty got=%b want=0", inst_valid_o); end
        step();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_gnt_hold();
        test_reset_mid();
`ifdef FETCH_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
